// File: rtl/rr_mux_arb_if.sv
// -----------------------------------------------------------------------------
// rr_mux_arb_if
//   Handshake bundle between the N competing producers, the round-robin
//   arbiter and the single downstream consumer.
//
//   Parameters
//     width    : data width per channel
//     channels : number of input channels
//
//   Signals
//     in_valid  [channels]       per-channel request, bit i = channel i
//     in_data   [channels*width] flattened data, channel i at [i*width +: width]
//     in_ready  [channels]       per-channel accept, at most one bit high
//     out_valid                  output buffer holds a beat
//     out_data  [width]          head beat data
//     out_sel   [selw]           index of the channel that supplied the head
//     out_ready                  consumer takes the head beat this cycle
//
//   Modports
//     slave  : arbiter view (takes requests, drives the output)
//     master : environment view (producers + consumer)
// -----------------------------------------------------------------------------
interface rr_mux_arb_if #(
    parameter int width    = 32,
    parameter int channels = 8
);
    localparam int selw = $clog2(channels);

    logic [channels-1:0]       in_valid;
    logic [channels*width-1:0] in_data;
    logic [channels-1:0]       in_ready;
    logic                      out_valid;
    logic [width-1:0]          out_data;
    logic [selw-1:0]           out_sel;
    logic                      out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel,
        output out_ready
    );
endinterface

// File: rtl/rr_mux_arb.sv
// -----------------------------------------------------------------------------
// rr_mux_arb
//   Registered N-way multiplexer with round-robin arbitration. Each cycle the
//   first requesting channel at or after the priority pointer is granted, its
//   data and index are captured into the output buffer, and the pointer moves
//   to the channel just after the winner.
//
//   Parameters
//     width    : data width per channel (>= 1)
//     channels : number of input channels (>= 2, any value)
//     selw     : derived index width, $clog2(channels)
//
//   Ports
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset; clears buffer, outputs, pointer
//     bus   : rr_mux_arb_if.slave (requests in, registered beat out)
//
//   Build option
//     RR_MUX_ARB_SKID_EN undefined : single output register; in_ready depends
//                                    combinationally on out_ready.
//     RR_MUX_ARB_SKID_EN defined   : two-entry head+skid FIFO; grant enable is
//                                    a registered condition (occupancy < 2),
//                                    so out_ready never reaches in_ready.
// -----------------------------------------------------------------------------
module rr_mux_arb #(
    parameter int width    = 32,
    parameter int channels = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_mux_arb_if.slave  bus
);
    localparam int selw = $clog2(channels);

    typedef struct packed {
        logic [width-1:0] data;
        logic [selw-1:0]  sel;
    } beat_t;

    // ------------------------------------------------------------------
    // Input view
    // ------------------------------------------------------------------
    logic [channels-1:0][width-1:0] in_data_a;
    assign in_data_a = bus.in_data;

    // ------------------------------------------------------------------
    // Round-robin search
    // ------------------------------------------------------------------
    logic [selw-1:0] ptr_q, ptr_d;
    logic [selw-1:0] win;
    logic            any_req;
    logic            grant_en;
    logic            push;
    logic            pop;
    logic            out_valid;
    beat_t           new_beat;
    logic [channels-1:0] in_ready_d;

    // Walk offsets from far to near so the nearest requester (smallest
    // offset from ptr) is the last one written and therefore wins.
    always_comb begin
        int              idx;
        logic [selw-1:0] idx_s;
        win     = '0;
        any_req = 1'b0;
        idx     = 0;
        idx_s   = '0;
        for (int j = channels - 1; j >= 0; j--) begin
            idx = int'(ptr_q) + j;
            if (idx >= channels) idx = idx - channels;
            idx_s = selw'(idx);
            if (bus.in_valid[idx_s]) begin
                win     = idx_s;
                any_req = 1'b1;
            end
        end
    end

    assign new_beat.data = in_data_a[win];
    assign new_beat.sel  = win;

    assign push = any_req && grant_en;
    assign pop  = out_valid && bus.out_ready;

    always_comb begin
        in_ready_d = '0;
        if (push) in_ready_d[win] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (push) begin
            if (win == selw'(channels - 1)) ptr_d = '0;
            else                            ptr_d = win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    beat_t head_q;

`ifdef RR_MUX_ARB_SKID_EN
    beat_t      skid_q;
    logic [1:0] cnt_q;

    // Occupancy is registered, so grant enable never sees out_ready.
    assign grant_en  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            skid_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (push) begin
                        head_q <= new_beat;
                        cnt_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        // drain and refill in the same cycle
                        head_q <= new_beat;
                    end else if (push) begin
                        skid_q <= new_beat;
                        cnt_q  <= 2'd2;
                    end else if (pop) begin
                        cnt_q  <= 2'd0;
                    end
                end
                default: begin
                    // full: no grant this cycle, only the skid can advance
                    if (pop) begin
                        head_q <= skid_q;
                        cnt_q  <= 2'd1;
                    end
                end
            endcase
        end
    end
`else
    logic head_vld_q;

    // Refill is allowed when the head is empty or leaves this cycle.
    assign grant_en  = !head_vld_q || bus.out_ready;
    assign out_valid = head_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else if (push) begin
            head_q     <= new_beat;
            head_vld_q <= 1'b1;
        end else if (pop) begin
            head_vld_q <= 1'b0;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = in_ready_d;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = head_q.data;
    assign bus.out_sel   = head_q.sel;

endmodule

// File: tb/tb_rr_mux_arb.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_arb
//   Self-checking bench: an 8-channel instance driven by directed and random
//   traffic against a queue-based reference model, plus a 5-channel instance
//   for pointer wrap on a non-power-of-two channel count.
// -----------------------------------------------------------------------------
module tb_rr_mux_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_mux_arb_if #(.width(32), .channels(8)) b8 ();
    rr_mux_arb_if #(.width(32), .channels(5)) b5 ();

    rr_mux_arb #(.width(32), .channels(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8.slave)
    );

    rr_mux_arb #(.width(32), .channels(5)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b5.slave)
    );

    typedef struct {
        logic [31:0] d;
        int          s;
    } beat_t;

    beat_t mq[$];   // expected output beats, head first
    int    mptr;    // model priority pointer
    int    n_chk = 0;
    int    n_err = 0;

    logic [7:0]  o_ir;
    logic        o_ov;
    logic [31:0] o_od;
    logic [2:0]  o_os;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle on the 8-channel instance: drive, compare against the model,
    // then advance the model to the state after the coming rising edge.
    task automatic step8(input logic [7:0] v, input logic [7:0][31:0] d, input logic rdy);
        int         g;
        logic [2:0] c3;
        logic [2:0] g3;
        logic       en;
        logic [7:0] exp_ir;
        beat_t      b;
        @(negedge clk);
        b8.in_valid  = v;
        b8.in_data   = d;
        b8.out_ready = rdy;
        #2;
        o_ir = b8.in_ready;
        o_ov = b8.out_valid;
        o_od = b8.out_data;
        o_os = b8.out_sel;
        chk("out_valid", o_ov, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("out_data", o_od, mq[0].d);
            chk("out_sel", o_os, mq[0].s);
        end
`ifdef RR_MUX_ARB_SKID_EN
        en = mq.size() < 2;
`else
        en = (mq.size() == 0) || rdy;
`endif
        g = -1;
        for (int k = 0; k < 8; k++) begin
            c3 = 3'((mptr + k) % 8);
            if (v[c3] && g < 0) g = int'(c3);
        end
        exp_ir = '0;
        g3 = 3'(g < 0 ? 0 : g);
        if (en && g >= 0) exp_ir[g3] = 1'b1;
        chk("in_ready", o_ir, exp_ir);
        chk("onehot", $countones(o_ir) <= 1, 1);
        if (mq.size() != 0 && rdy) void'(mq.pop_front());
        if (exp_ir != 0) begin
            b.d = d[g3];
            b.s = g;
            mq.push_back(b);
            mptr = (g + 1) % 8;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        b8.in_valid = '0;
        b5.in_valid = '0;
        #1;
        chk("rst_out_valid", b8.out_valid, 0);
        chk("rst_out_data", b8.out_data, 0);
        chk("rst_out_sel", b8.out_sel, 0);
        chk("rst5_out_valid", b5.out_valid, 0);
        mq.delete();
        mptr = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0][31:0] dd;
    logic [4:0][31:0] d5;
    logic [7:0]       pend_v;
    logic [7:0][31:0] pend_d;
    int               waitc[8];
    int               pv, pr;
    logic [31:0]      bpd;
    int               acc;
    logic             pending;

    initial begin
        b8.in_valid = '0; b8.in_data = '0; b8.out_ready = 1'b1;
        b5.in_valid = '0; b5.in_data = '0; b5.out_ready = 1'b1;
        mptr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_out_valid", b8.out_valid, 0);
        chk("init_out_data", b8.out_data, 0);
        chk("init_out_sel", b8.out_sel, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin, all channels valid
        for (int i = 0; i < 8; i++) dd[i] = 32'h100 + 32'(i);
        for (int c = 0; c < 10; c++) begin
            step8(8'hFF, dd, 1'b1);
            if (c >= 1) begin
                chk("rr_sel", o_os, (c - 1) % 8);
                chk("rr_data", o_od, 32'h100 + 32'((c - 1) % 8));
            end
        end

        // Reset mid-stream with a valid beat, then first grant goes to 0
        chk("pre_rst_valid", b8.out_valid, 1);
        do_reset();
        step8(8'hFF, dd, 1'b1);
        chk("rst_first_grant", o_ir, 8'h01);

        // Sparse: channels 2 and 6
        do_reset();
        dd = '0; dd[2] = 32'h2; dd[6] = 32'h6;
        step8(8'h44, dd, 1'b1); chk("sp_g0", o_ir, 8'h04);
        step8(8'h44, dd, 1'b1); chk("sp_g1", o_ir, 8'h40);
        step8(8'h44, dd, 1'b1); chk("sp_g2", o_ir, 8'h04);
        step8(8'h44, dd, 1'b1); chk("sp_g3", o_ir, 8'h40);
        step8(8'h04, dd, 1'b1); chk("sp_g4", o_ir, 8'h04);
        step8(8'h04, dd, 1'b1); chk("sp_g5", o_ir, 8'h04);
        step8(8'h00, dd, 1'b1);
        step8(8'h00, dd, 1'b1);

        // Backpressure on channel 3
        do_reset();
        dd = '0; dd[3] = 32'hDEADBEEF;
        step8(8'h08, dd, 1'b0);
        chk("bp_first", o_ir, 8'h08);
        bpd = 32'hCAFE0001;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            dd[3] = bpd;
            step8(8'h08, dd, 1'b0);
            chk("bp_hold_data", o_od, 32'hDEADBEEF);
            chk("bp_hold_sel", o_os, 3);
            if (o_ir[3]) begin acc++; bpd++; end
        end
`ifdef RR_MUX_ARB_SKID_EN
        chk("bp_extra_acc", acc, 1);
`else
        chk("bp_extra_acc", acc, 0);
`endif
        pending = 1'b1;
        for (int c = 0; c < 5; c++) begin
            dd[3] = bpd;
            step8(pending ? 8'h08 : 8'h00, dd, 1'b1);
            if (c == 0) chk("bp_drain_head", o_od, 32'hDEADBEEF);
            if (o_ir[3]) pending = 1'b0;
        end
        chk("bp_drained", mq.size(), 0);

        // Wrap on the 5-channel instance
        d5 = '0; d5[4] = 32'h44;
        @(negedge clk);
        b5.in_valid = 5'b10000; b5.in_data = d5; b5.out_ready = 1'b1;
        #2;
        chk("w5_g4", b5.in_ready, 5'b10000);
        @(negedge clk);
        d5[0] = 32'h40; d5[4] = 32'h45;
        b5.in_valid = 5'b10001; b5.in_data = d5;
        #2;
        chk("w5_g0", b5.in_ready, 5'b00001);
        chk("w5_sel4", b5.out_sel, 3'd4);
        chk("w5_data4", b5.out_data, 32'h44);
        @(negedge clk);
        b5.in_valid = 5'b10000;
        #2;
        chk("w5_valid", b5.out_valid, 1);
        chk("w5_sel0", b5.out_sel, 3'd0);
        chk("w5_data0", b5.out_data, 32'h40);
        @(negedge clk);
        b5.in_valid = 5'b00000;

        // Random traffic; inputs hold until accepted
        do_reset();
        pend_v = '0;
        pend_d = '0;
        for (int i = 0; i < 8; i++) waitc[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            pv = (cyc / 1000) % 3 == 0 ? 95 : ((cyc / 1000) % 3 == 1 ? 40 : 10);
            pr = (cyc / 500) % 2 == 0 ? 80 : 30;
            for (int i = 0; i < 8; i++) begin
                if (!pend_v[i]) begin
                    pend_v[i] = ($urandom_range(0, 99) < pv);
                    pend_d[i] = $urandom;
                end
            end
            step8(pend_v, pend_d, $urandom_range(0, 99) < pr);
            if (o_ir != 0) begin
                for (int i = 0; i < 8; i++) begin
                    if (o_ir[i]) begin
                        chk("fair", waitc[i] <= 7, 1);
                        waitc[i] = 0;
                    end else if (pend_v[i]) begin
                        waitc[i]++;
                    end
                end
            end
            pend_v = pend_v & ~o_ir;
            for (int i = 0; i < 8; i++) if (!pend_v[i]) waitc[i] = 0;
        end
        for (int c = 0; c < 4; c++) step8(8'h00, pend_d, 1'b1);
        chk("final_empty", mq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
